gpif_burst_reader: RTL and testbench
====================================

// Module: gpif_burst_reader
// PURPOSE
// - Host-side (FX3-end) counterpart of the FPGA GPIF sample interface: drives collectData/readData, captures 16-bit words.
// - Reads fixed-length bursts whenever dataAvailable is high; counts bursts, flags buffer errors, optionally checks the test pattern.
// - Used for on-board loopback/self-test, with a second FPGA, or as a synthesizable bench master for the capture path.
// PARAMETERS
// - BURST_WORDS   default 8192  words read per dataAvailable assertion (>=2)
// - READ_LATENCY  default 2     cycles from readData rising to first valid word on databus (1..7)
// - DATA_WIDTH    default 16    databus width
// PORTS
// - clock          in   1   GPIF clock (60 MHz); all logic on rising edge
// - nReset         in   1   asynchronous active-low reset
// - enable         in   1   1 = run capture session; 0 = stop after current burst
// - dataAvailable  in   1   producer has >= BURST_WORDS words buffered
// - bufferError    in   1   producer overflow flag
// - databus        in   16  sample data from producer
// - collectData    out  1   request producer to buffer samples
// - readData       out  1   read strobe to producer
// - wordValid      out  1   wordOut valid this cycle
// - wordOut        out  16  registered captured word
// - burstCount     out  32  completed bursts since reset/session start (wraps at 2^32)
// - overflowSeen   out  1   sticky: bufferError seen during session
// - patternErrors  out  16  pattern mismatches, saturating at 16'hFFFF
// - busy           out  1   high in any state except IDLE
// BEHAVIOUR
// - Reset (async, any state, mid-burst included): all outputs 0, FSM=IDLE, counters 0; release sync to clock.
// - States: IDLE -> ARM -> REQ -> XFER -> DONE -> ARM|IDLE.
// - IDLE: collectData=0, readData=0. enable=1 -> ARM; entry clears burstCount, overflowSeen, patternErrors, seed flag.
// - ARM: collectData=1. dataAvailable=1 -> REQ next cycle. enable=0 while in ARM -> IDLE (collectData drops next cycle).
// - REQ/XFER: readData=1 for exactly BURST_WORDS consecutive cycles starting on entry to REQ (cycle T).
// - Word k (0..BURST_WORDS-1) is sampled from databus at T+READ_LATENCY+k; wordOut/wordValid asserted one cycle later.
// - Capture-window counter and read-strobe counter are independent; readData falls before last capture when READ_LATENCY>0.
// - DONE: entered the cycle after last word sampled; burstCount+1; enable=1 -> ARM, else IDLE.
// - enable falling mid-burst: burst completes in full, then IDLE; never truncate a burst.
// - dataAvailable dropping during REQ/XFER: ignored (burst length is fixed).
// - collectData held 1 from ARM through DONE; bufferError=1 any cycle while busy -> overflowSeen=1 (sticky until IDLE exit).
// - wordValid never high in IDLE/ARM; exactly BURST_WORDS wordValid pulses per burst.
// CONFIGURATION
// - PATTERN_CHECK_EN defined: checks producer test-mode data: bits[9:0] increment by 1 mod 1024 per word, bits[15:10]=0.
//   First word of session seeds the expectation (no check); expectation carries across bursts; mismatch -> patternErrors+1
//   (saturating) and re-seed from received word. Check is registered alongside wordValid.
// - PATTERN_CHECK_EN undefined: no checker logic; patternErrors tied 0.
// TESTING
// - Reset, enable=1, dataAvailable=0 -> collectData=1, readData=0, busy=1, wordValid=0 indefinitely.
// - BURST_WORDS=16, READ_LATENCY=2, dataAvailable=1 at T -> readData high T+1..T+16, 16 wordValid pulses, burstCount=1.
// - Producer model emitting 0..1023 wrap, 3 bursts of 8192, PATTERN_CHECK_EN -> patternErrors=0, burstCount=3.
// - Inject one corrupted word (0x0155 expected 0x0154) -> patternErrors=1, next word 0x0156 no new error.
// - enable=0 at burst word 100 -> burst completes (all words), then IDLE, collectData=0, burstCount=1.
// - bufferError pulse 1 cycle mid-burst -> overflowSeen=1 held; nReset low mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/gpif_burst_reader.sv
// gpif_burst_reader: host-side GPIF master that reads fixed-length bursts of words from a producer.
//
// Ports:
//   clock, nReset             rising-edge clock, asynchronous active-low reset
//   enable                    1 = run a capture session, 0 = stop once the current burst has finished
//   dataAvailable             producer has at least BURST_WORDS words buffered
//   bufferError               producer overflow flag
//   databus                   sample data from the producer
//   collectData, readData     buffering request and read strobe to the producer
//   wordValid, wordOut        captured word, registered, valid for one cycle
//   burstCount                number of bursts completed in this session (wraps)
//   overflowSeen              sticky flag: bufferError was seen while busy
//   patternErrors             saturating count of test-pattern mismatches
//   busy                      high in any state other than IDLE
//
// Build option: define PATTERN_CHECK_EN to check the producer test pattern.
// The pattern is: bits [9:0] count up by 1 mod 1024, and every higher bit is 0.
// Without the macro, patternErrors is tied to zero.
module gpif_burst_reader #(
    parameter int BURST_WORDS  = 8192,
    parameter int READ_LATENCY = 2,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  enable,
    input  logic                  dataAvailable,
    input  logic                  bufferError,
    input  logic [DATA_WIDTH-1:0] databus,
    output logic                  collectData,
    output logic                  readData,
    output logic                  wordValid,
    output logic [DATA_WIDTH-1:0] wordOut,
    output logic [31:0]           burstCount,
    output logic                  overflowSeen,
    output logic [15:0]           patternErrors,
    output logic                  busy
);
    localparam int CW = $clog2(BURST_WORDS + 1);

    typedef enum logic [2:0] {IDLE, ARM, REQ, XFER, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CW-1:0]           rd_cnt, cap_cnt;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic                    sample, last_sample, session_start;

    // The read strobe, delayed by READ_LATENCY cycles, marks the cycles whose databus holds a word.
    assign sample        = rd_pipe[READ_LATENCY-1];
    assign last_sample   = sample && cap_cnt == CW'(BURST_WORDS - 1);
    assign session_start = state == IDLE && enable;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        collectData = 1'b1;
        readData    = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                collectData = 1'b0;
                busy        = 1'b0;
                if (enable) state_nxt = ARM;
            end
            ARM:  state_nxt = !enable ? IDLE : dataAvailable ? REQ : ARM;
            REQ: begin
                readData  = 1'b1;
                state_nxt = XFER;
            end
            // The burst length is fixed, so a falling enable or dataAvailable is ignored here.
            XFER: begin
                readData = rd_cnt < CW'(BURST_WORDS);
                if (last_sample) state_nxt = DONE;
            end
            DONE:    state_nxt = enable ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes issued and words captured are counted separately.
    // With READ_LATENCY > 0, the strobe ends while captures are still arriving.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rd_cnt  <= '0;
            cap_cnt <= '0;
            rd_pipe <= '0;
        end else begin
            if (state == REQ || state == XFER) begin
                if (readData) rd_cnt <= rd_cnt + 1'b1;
            end else begin
                rd_cnt <= '0;
            end
            if (sample) cap_cnt <= last_sample ? '0 : cap_cnt + 1'b1;
            rd_pipe <= READ_LATENCY'({rd_pipe, readData});
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            wordValid    <= 1'b0;
            wordOut      <= '0;
            burstCount   <= '0;
            overflowSeen <= 1'b0;
        end else begin
            wordValid <= sample;
            if (sample) wordOut <= databus;
            if (session_start)    burstCount <= '0;
            else if (last_sample) burstCount <= burstCount + 32'd1;
            if (session_start)            overflowSeen <= 1'b0;
            else if (busy && bufferError) overflowSeen <= 1'b1;
        end
    end

`ifdef PATTERN_CHECK_EN
    logic       seeded;
    logic [9:0] exp_lo;
    logic       pat_ok;

    assign pat_ok = databus == DATA_WIDTH'(exp_lo);

    // The next expected word is always the received word + 1.
    // On a match this simply advances the expectation; on a mismatch it re-seeds from the received word.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            seeded        <= 1'b0;
            exp_lo        <= '0;
            patternErrors <= '0;
        end else if (session_start) begin
            seeded        <= 1'b0;
            exp_lo        <= '0;
            patternErrors <= '0;
        end else if (sample) begin
            seeded <= 1'b1;
            exp_lo <= databus[9:0] + 10'd1;
            if (seeded && !pat_ok && patternErrors != 16'hFFFF)
                patternErrors <= patternErrors + 16'd1;
        end
    end
`else
    assign patternErrors = '0;
`endif

endmodule

// File: tb/tb_gpif_burst_reader.sv
// tb_gpif_burst_reader: directed, table-driven bench for gpif_burst_reader (BURST_WORDS=16, READ_LATENCY=2).
module tb_gpif_burst_reader;
    localparam int BW = 16;
    localparam int RL = 2;

`ifdef PATTERN_CHECK_EN
    localparam logic [15:0] SKIP_ERRS = 16'd1;
`else
    localparam logic [15:0] SKIP_ERRS = 16'd0;
`endif

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic        enable = 1'b0;
    logic        dataAvailable = 1'b0;
    logic        bufferError = 1'b0;
    logic [15:0] databus = '0;
    logic        collectData, readData, wordValid, overflowSeen, busy;
    logic [15:0] wordOut, patternErrors;
    logic [31:0] burstCount;

    int checks = 0;
    int fails = 0;

    // Producer model: word k of a burst appears on databus RL cycles after the k-th read strobe.
    logic [15:0] prod = '0;
    bit          skip = 1'b0;
    bit          s1 = 1'b0, s2 = 1'b0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic       en;
        logic       da;
        logic [3:0] exp;   // {collectData, readData, busy, wordValid}
    } vec_t;
    vec_t vt[7];

    always #5 clock = ~clock;

    gpif_burst_reader #(.BURST_WORDS(BW), .READ_LATENCY(RL), .DATA_WIDTH(16)) dut (
        .clock(clock), .nReset(nReset), .enable(enable), .dataAvailable(dataAvailable),
        .bufferError(bufferError), .databus(databus), .collectData(collectData),
        .readData(readData), .wordValid(wordValid), .wordOut(wordOut),
        .burstCount(burstCount), .overflowSeen(overflowSeen),
        .patternErrors(patternErrors), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_bc(input string name, input logic [31:0] target, input int limit);
        for (int i = 0; i < limit; i++) begin
            tick();
            if (burstCount == target) break;
        end
        chk(name, burstCount, target);
    endtask

    task automatic start_burst(input string name);
        @(negedge clock);
        dataAvailable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (readData) break;
        end
        dataAvailable = 1'b0;
        chk(name, readData, 1'b1);
    endtask

    initial forever begin
        @(negedge clock);
        if (!nReset) begin
            s1 = 1'b0;
            s2 = 1'b0;
            exp_q.delete();
        end else begin
            if (s2) begin
                if (skip) begin
                    prod = (prod + 16'd1) & 16'h03FF;
                    skip = 1'b0;
                end
                databus = prod;
                exp_q.push_back(prod);
                prod = (prod + 16'd1) & 16'h03FF;
            end
            s2 = s1;
            s1 = readData;
        end
    end

    // Scoreboard: every captured word must match what the producer drove, in order.
    initial forever begin
        tick();
        if (wordValid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL word_unexpected: got %0h expected none", wordOut);
            end else begin
                chk("wordOut", wordOut, exp_q.pop_front());
            end
        end
    end

    initial begin
        int first_rd, last_rd, n_rd, first_wv, last_wv, n_wv, bad;

        vt[0] = '{1'b0, 1'b0, 4'b0000};
        vt[1] = '{1'b1, 1'b0, 4'b1010};
        vt[2] = '{1'b1, 1'b0, 4'b1010};
        vt[3] = '{1'b0, 1'b0, 4'b0000};
        vt[4] = '{1'b1, 1'b0, 4'b1010};
        vt[5] = '{1'b0, 1'b0, 4'b0000};
        vt[6] = '{1'b0, 1'b1, 4'b0000};

        repeat (3) tick();
        chk("reset_outputs", {collectData, readData, wordValid, overflowSeen, busy,
                              |wordOut, |burstCount, |patternErrors}, 8'h00);
        @(posedge clock);
        #3 nReset = 1'b1;

        foreach (vt[i]) begin
            @(negedge clock);
            enable        = vt[i].en;
            dataAvailable = vt[i].da;
            tick();
            chk($sformatf("vec%0d", i), {collectData, readData, busy, wordValid}, vt[i].exp);
        end

        // Armed with no data available: the reader waits without reading.
        @(negedge clock);
        enable        = 1'b1;
        dataAvailable = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if ({collectData, readData, busy, wordValid} != 4'b1010) bad++;
        end
        chk("arm_hold_bad_cycles", bad, 0);

        // One burst, timed relative to the edge at which ARM sees dataAvailable.
        @(negedge clock);
        dataAvailable = 1'b1;
        first_rd = 0; last_rd = 0; n_rd = 0;
        first_wv = 0; last_wv = 0; n_wv = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) dataAvailable = 1'b0;
            if (readData) begin
                if (n_rd == 0) first_rd = i;
                last_rd = i;
                n_rd++;
            end
            if (wordValid) begin
                if (n_wv == 0) first_wv = i;
                last_wv = i;
                n_wv++;
            end
            if (i == 18) chk("bc_before_done", burstCount, 0);
            if (i == 19) chk("bc_at_done", burstCount, 1);
        end
        chk("rd_first", first_rd, 1);
        chk("rd_last", last_rd, 16);
        chk("rd_count", n_rd, BW);
        chk("wv_first", first_wv, 4);
        chk("wv_last", last_wv, 19);
        chk("wv_count", n_wv, BW);
        chk("after_burst_flags", {collectData, readData, busy, wordValid, overflowSeen}, 5'b10100);

        // Three back-to-back bursts with dataAvailable held high; the pattern continues across bursts.
        @(negedge clock);
        dataAvailable = 1'b1;
        wait_bc("bc_back_to_back", 4, 200);
        dataAvailable = 1'b0;
        chk("pattern_clean", patternErrors, 0);

        // The producer skips one value at the start of the next burst.
        @(negedge clock);
        skip = 1'b1;
        start_burst("skip_start");
        wait_bc("bc_skip", 5, 60);
        chk("pattern_skip", patternErrors, SKIP_ERRS);

        // enable falls mid-burst and bufferError pulses for one cycle.
        // The burst still runs to completion, then the reader returns to IDLE.
        start_burst("drop_start");
        n_wv = 0;
        for (int j = 1; j <= 60; j++) begin
            tick();
            if (wordValid) n_wv++;
            if (j == 5) enable = 1'b0;
            if (j == 7) bufferError = 1'b1;
            if (j == 8) bufferError = 1'b0;
            if (!busy) break;
        end
        chk("drop_wv_count", n_wv, BW);
        chk("drop_bc", burstCount, 6);
        chk("drop_idle", {collectData, readData, busy}, 3'b000);
        chk("drop_overflow", overflowSeen, 1'b1);
        repeat (3) tick();
        chk("idle_sticky", {overflowSeen, burstCount}, {1'b1, 32'd6});

        // Starting a new session clears the counters and flags.
        @(negedge clock);
        enable = 1'b1;
        tick();
        chk("session_clear", {overflowSeen, burstCount, patternErrors}, 49'd0);

        // Asynchronous reset in the middle of the second burst.
        start_burst("rst_first_start");
        wait_bc("rst_bc1", 1, 60);
        start_burst("rst_second_start");
        repeat (4) tick();
        bufferError = 1'b1;
        tick();
        bufferError = 1'b0;
        chk("pre_reset_state", {overflowSeen, busy, wordValid}, 3'b111);
        @(negedge clock);
        #2 nReset = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_reset_outputs", {collectData, readData, wordValid, overflowSeen, busy,
                                    |wordOut, |burstCount, |patternErrors}, 8'h00);
        tick();
        @(posedge clock);
        #3 nReset = 1'b1;
        tick();
        chk("post_reset_idle", {collectData, readData, busy, wordValid}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
